// File: rtl/radix4_seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_seq_divider_if
//  Description : Request/result handshake bundle for the radix-4 sequential
//                divider. The master drives requests and consumes results;
//                the slave is the divider itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface radix4_seq_divider_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/radix4_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_seq_divider
//  Description : Sequential unsigned N-bit divider, radix-4 restoring, two
//                quotient bits per cycle. Valid/ready request and result
//                ports; one operation in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module radix4_seq_divider #(
    parameter int N = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    radix4_seq_divider_if.slave   bus
);

    // Odd widths cannot be retired two bits at a time.
    if ((N % 2) != 0 || N < 2) begin : g_bad_width
        $error("radix4_seq_divider: N must be even and >= 2");
    end

    localparam int              c_cnt_w    = (N / 2 > 1) ? $clog2(N / 2) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(N / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [N-1:0]         r_d;
    logic [N-1:0]         r_q;
    logic [N+1:0]         r_r;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_dbz;

    logic                 r_out_valid;
    logic [N-1:0]         r_quotient;
    logic [N-1:0]         r_remainder;
    logic                 r_div_by_zero;

    logic                 w_accept;
    logic                 w_out_fire;
    logic [N+1:0]         w_rs;
    logic [N+1:0]         w_d1;
    logic [N+1:0]         w_d2;
    logic [N+1:0]         w_d3;
    logic [1:0]           w_digit;
    logic [N+1:0]         w_r_next;
    logic [N-1:0]         w_q_next;

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_out_fire = r_out_valid && bus.out_ready;

    // Partial remainder shifted left by one radix-4 digit, plus the next two
    // dividend bits. R < D always holds, so no significant bit is lost.
    assign w_rs = (r_r << 2) | (N+2)'(r_q[N-1:N-2]);
    assign w_d1 = {2'b00, r_d};
    assign w_d2 = {1'b0, r_d, 1'b0};
    assign w_d3 = w_d1 + w_d2;

    // Choose the largest digit k with k*D <= shifted remainder and subtract.
    always_comb begin
        w_digit  = 2'd0;
        w_r_next = w_rs;
        if (w_rs >= w_d3) begin
            w_digit  = 2'd3;
            w_r_next = w_rs - w_d3;
        end else if (w_rs >= w_d2) begin
            w_digit  = 2'd2;
            w_r_next = w_rs - w_d2;
        end else if (w_rs >= w_d1) begin
            w_digit  = 2'd1;
            w_r_next = w_rs - w_d1;
        end
    end

    assign w_q_next = (r_q << 2) | N'(w_digit);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Iteration datapath: load on accept, one digit per CALC cycle.
    // A zero divisor preloads the final divide-by-zero result directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d   <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_d   <= bus.divisor;
            r_cnt <= c_cnt_init;
            if (bus.divisor == '0) begin
                r_q   <= '1;
                r_r   <= {2'b00, bus.dividend};
                r_dbz <= 1'b1;
            end else begin
                r_q   <= bus.dividend;
                r_r   <= '0;
                r_dbz <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Result registers: captured on the first DONE cycle, held until the
    // next result so they stay stable under backpressure and afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (r_state == S_DONE && !r_out_valid) begin
            r_out_valid   <= 1'b1;
            r_quotient    <= r_q;
            r_remainder   <= r_r[N-1:0];
            r_div_by_zero <= r_dbz;
        end else if (w_out_fire) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_radix4_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radix4_seq_divider
//  Description : Directed and randomised self-checking bench for the radix-4
//                sequential divider (N = 32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_radix4_seq_divider;

    localparam int N = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    radix4_seq_divider_if #(.N(N)) bus ();

    radix4_seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one full operation starting #1 after a rising edge, with the
    // result handshake completing one cycle after out_valid rises.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_z;
        int          exp_lat;
        int          n;
        if (b == 32'd0) begin
            exp_q = 32'hFFFF_FFFF; exp_r = a; exp_z = 1'b1; exp_lat = 1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_z = 1'b0; exp_lat = N / 2 + 1;
        end
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
        chk({tag, ".quotient"}, 64'(bus.quotient), 64'(exp_q));
        chk({tag, ".remainder"}, 64'(bus.remainder), 64'(exp_r));
        chk({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_z));
        if (b != 32'd0) begin
            chk({tag, ".recon"}, 64'(bus.quotient) * 64'(b) + 64'(bus.remainder), 64'(a));
            chk({tag, ".r_lt_d"}, 64'(bus.remainder < b), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_clr"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hold_q;
        logic [31:0] hold_r;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.quotient", 64'(bus.quotient), 64'd0);
        chk("rst.remainder", 64'(bus.remainder), 64'd0);
        chk("rst.div_by_zero", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        do_op(32'd100, 32'd7, "d100_7");
        do_op(32'hFFFF_FFFF, 32'd1, "dmax_1");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dmax_max");
        do_op(32'hFFFF_FFFF, 32'd3, "dmax_3");
        do_op(32'd3, 32'd10, "d3_10");
        do_op(32'd0, 32'd5, "d0_5");
        do_op(32'd5, 32'd0, "d5_0");
        do_op(32'd9, 32'd2, "d9_2");

        // Backpressure: result held for 5 cycles while in_valid pulses.
        bus.in_valid = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp.busy_ready", 64'(bus.in_ready), 64'd0);
        repeat (N / 2 + 1) @(posedge clk);
        #1;
        chk("bp.valid", 64'(bus.out_valid), 64'd1);
        hold_q = bus.quotient;
        hold_r = bus.remainder;
        chk("bp.q", 64'(hold_q), 64'd142);
        chk("bp.r", 64'(hold_r), 64'd6);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            @(posedge clk); #1;
            chk("bp.hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp.hold_ready", 64'(bus.in_ready), 64'd0);
            chk("bp.hold_q", 64'(bus.quotient), 64'd142);
            chk("bp.hold_r", 64'(bus.remainder), 64'd6);
        end
        // Handshake with a simultaneous request: only the return to idle.
        bus.in_valid  = 1'b1;
        bus.dividend  = 32'd77;
        bus.divisor   = 32'd8;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("bp.idle_ready", 64'(bus.in_ready), 64'd1);
        chk("bp.idle_valid", 64'(bus.out_valid), 64'd0);
        chk("bp.keep_q", 64'(bus.quotient), 64'd142);
        do_op(32'd77, 32'd8, "bp_next");

        // Reset in the eighth CALC cycle discards the operation.
        bus.in_valid = 1'b1;
        bus.dividend = 32'd12345678;
        bus.divisor  = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid.busy", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid.in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid.quotient", 64'(bus.quotient), 64'd0);
        chk("mid.remainder", 64'(bus.remainder), 64'd0);
        chk("mid.div_by_zero", 64'(bus.div_by_zero), 64'd0);
        do_op(32'd1000, 32'd33, "after_rst");

        // Randomised pairs with emphasis on edge divisors.
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if (i % 7 == 0) a = 32'hFFFF_FFFF;
            case ($urandom_range(0, 5))
                0:       b = 32'd1;
                1:       b = 32'd2;
                2:       b = 32'd1 << $urandom_range(0, 31);
                3:       b = 32'hFFFF_FFFF;
                4:       b = $urandom_range(1, 1000);
                default: b = $urandom;
            endcase
            do_op(a, b, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
